// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle SLL/SRL/SRA execution unit.
// Uses one shift-by-2 stage per cycle, plus a final shift-by-1 when the
// shift amount is odd. The pipeline uses a start/busy/done handshake.
// Optional feature macro ITER_SHIFT_ROTR_EN: when defined, op=11 is
// rotate-right; otherwise op=11 behaves as SRL.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for a request
// SHIFT  | shifting in progress, busy=1
// DONE   | done=1 for one cycle; a new start is accepted here

module iter_shift_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [DATA_W-1:0]  work;
  logic [SHAMT_W-1:0] rem;
  logic               sign_q;

  logic               step_two;
  logic [SHAMT_W-1:0] rem_next;
  logic [DATA_W-1:0]  work_next;
  logic               accept;

  // Shift network for one SHIFT edge: by 2 while at least 2 remain, else by 1.
  always_comb begin
    step_two  = (rem >= SHAMT_W'(2));
    rem_next  = step_two ? (rem - SHAMT_W'(2)) : '0;
    work_next = work;
    case (op_q)
      OP_SLL: begin
        work_next = step_two ? {work[DATA_W-3:0], 2'b00}
                             : {work[DATA_W-2:0], 1'b0};
      end
      OP_SRA: begin
        work_next = step_two ? {{2{sign_q}}, work[DATA_W-1:2]}
                             : {sign_q, work[DATA_W-1:1]};
      end
`ifdef ITER_SHIFT_ROTR_EN
      OP_ROTR: begin
        work_next = step_two ? {work[1:0], work[DATA_W-1:2]}
                             : {work[0], work[DATA_W-1:1]};
      end
`else
      OP_ROTR: begin
        work_next = step_two ? {2'b00, work[DATA_W-1:2]}
                             : {1'b0, work[DATA_W-1:1]};
      end
`endif
      OP_SRL: begin
        work_next = step_two ? {2'b00, work[DATA_W-1:2]}
                             : {1'b0, work[DATA_W-1:1]};
      end
      default: begin
        work_next = work;
      end
    endcase
  end

  // A start is accepted only when not shifting and not being flushed.
  always_comb begin
    accept = start && !flush && (state != S_SHIFT);
  end

  // Control FSM with registered busy/done/result; reset beats flush beats start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rem    <= '0;
      work   <= '0;
      op_q   <= OP_SLL;
      sign_q <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
          if (accept) begin
            op_q   <= op;
            work   <= data_in;
            rem    <= shamt;
            sign_q <= data_in[DATA_W-1];
            if (shamt == '0) begin
              result <= data_in;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          work <= work_next;
          rem  <= rem_next;
          if (rem_next == '0) begin
            result <= work_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed testbench for iter_shift_unit with hand-computed expectations.
module tb_iter_shift_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_errors;

  iter_shift_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .data_in (data_in),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an accepted request and follow it until done; returns in the DONE cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [4:0] s,
                        input logic [31:0] d, input logic [31:0] exp_res);
    int nbusy;
    int n;
    start = 1'b1; op = o; shamt = s; data_in = d;
    tick();
    start = 1'b0; op = 2'b00; shamt = 5'd0; data_in = 32'hDEAD_BEEF;
    nbusy = 0;
    n = 0;
    while (!done && n < 100) begin
      if (busy) nbusy++;
      tick();
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busycyc"}, nbusy, (s + 1) / 2);
    chk({tag, "_result"}, result, exp_res);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; start = 1'b0; op = 2'b00; shamt = 5'd0; data_in = 32'd0; flush = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b0;
    tick();

    // 1: SRL by odd amount
    run_op("srl5", 2'b01, 5'd5, 32'hF000_0000, 32'h0780_0000);
    tick();
    chk("srl5_done_pulse", {31'd0, done}, 32'd0);
    chk("srl5_hold", result, 32'h0780_0000);

    // 2: SRA boundary and positive operand
    run_op("sra31", 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    run_op("sra4", 2'b10, 5'd4, 32'h7FFF_FFFF, 32'h07FF_FFFF);
    tick();
    run_op("sra3", 2'b10, 5'd3, 32'h8000_0000, 32'hF000_0000);
    tick();
    run_op("sll4", 2'b00, 5'd4, 32'h1234_5678, 32'h2345_6780);
    tick();

    // 3: zero shift, then back-to-back start in the DONE cycle
    run_op("sll0", 2'b00, 5'd0, 32'h0000_0001, 32'h0000_0001);
    run_op("sll31_b2b", 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000);
    tick();

    // 4: start during busy is ignored
    start = 1'b1; op = 2'b01; shamt = 5'd20; data_in = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op = 2'b00; shamt = 5'd1; data_in = 32'h0000_0055;
    tick();
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (!done && n < 100) begin tick(); n++; end
      chk("ign_done", {31'd0, done}, 32'd1);
      chk("ign_cycles", n, 8);
    end
    chk("ign_result", result, 32'h0000_0FFF);
    tick();

    // 5a: flush on the third SHIFT cycle
    start = 1'b1; op = 2'b00; shamt = 5'd16; data_in = 32'h1234_5678;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("fl_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy", {31'd0, busy}, 32'd0);
    chk("fl_done", {31'd0, done}, 32'd0);
    chk("fl_result", result, 32'h0000_0FFF);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done || busy) seen++;
      end
      chk("fl_quiet", seen, 0);
    end

    // flush with start in the same cycle: not accepted
    start = 1'b1; flush = 1'b1; op = 2'b01; shamt = 5'd0; data_in = 32'hAAAA_AAAA;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flst_done", {31'd0, done}, 32'd0);
    chk("flst_result", result, 32'h0000_0FFF);
    tick();

    // 5b: reset mid-operation
    start = 1'b1; op = 2'b00; shamt = 5'd16; data_in = 32'h1234_5678;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_done", {31'd0, done}, 32'd0);
    chk("rm_result", result, 32'd0);
    tick();

    // 6: op=11
`ifdef ITER_SHIFT_ROTR_EN
    run_op("op11", 2'b11, 5'd1, 32'h0000_0003, 32'h8000_0001);
    tick();
    run_op("op11_4", 2'b11, 5'd4, 32'h0000_00A5, 32'h5000_000A);
`else
    run_op("op11", 2'b11, 5'd1, 32'h0000_0003, 32'h0000_0001);
    tick();
    run_op("op11_4", 2'b11, 5'd4, 32'h0000_00A5, 32'h0000_000A);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
